// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one UART tx line.
// Define UART_ARB_ODD_PARITY_EN for odd parity (even parity otherwise).
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int ID_W     = 2,
  parameter int GAP_BITS = 1
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_1,
  output logic              busy,
  output logic [ID_W-1:0]   cur_id,
  output logic              done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]      state;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [2:0]      bit_cnt;
  logic [3:0]      gap_cnt;
  logic [ID_W-1:0] rr_ptr;

  logic            found;
  logic [ID_W-1:0] win;
  logic [7:0]      win_byte;
  logic            win_par;

  // Search starts just past the last winner, so priority rotates.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    win      = '0;
    win_byte = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = ID_W'(idx);
        win_byte = din[8*idx +: 8];
      end
    end
  end

`ifdef UART_ARB_ODD_PARITY_EN
  assign win_par = ~^win_byte;
`else
  assign win_par = ^win_byte;
`endif

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_1      <= 1'b1;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_id    <= '0;
      rr_ptr    <= ID_W'(NREQ - 1);
      shift_reg <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_1 <= 1'b1;
          if (found) begin
            shift_reg <= win_byte;
            par_bit   <= win_par;
            gnt       <= ONE << win;
            cur_id    <= win;
            rr_ptr    <= win;
            tx_1      <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          tx_1    <= shift_reg[7];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_1  <= par_bit;
            state <= PARITY;
          end else begin
            tx_1 <= shift_reg[6];
          end
        end
        PARITY: begin
          tx_1  <= 1'b1;
          state <= STOP;
        end
        STOP: begin
          if (GAP_BITS > 0) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == 4'(GAP_BITS - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
